seq_restoring_div: RTL and testbench

//  Sequential restoring divider: the inverse of the approx-multiplier datapath. Divides a 2*DW-bit

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step.sv | 31 +++
 rtl/seq_restoring_div.sv | 175 +++++++++++++++++
 tb/tb_seq_restoring_div.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings and default widths.
package div_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } div_state_e;

    localparam int DIV_DW_DEFAULT    = 8;
    localparam int DIV_TRUNC_DEFAULT = 2;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step
    import div_pkg::*;
#(
    parameter int DW = DIV_DW_DEFAULT
) (
    input  logic [DW-1:0] pr,
    input  logic          dividend_bit,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] pr_next,
    output logic          q_bit
);

    logic [DW:0] shifted_s;
    logic [DW:0] diff_s;

    // The incoming pr is always below divisor, so shifted_s < 2*divisor and the
    // borrow bit of the DW+1-bit difference is exactly the result of shifted_s < divisor.
    always_comb begin
        shifted_s = {pr, dividend_bit};
        diff_s    = shifted_s - {1'b0, divisor};
        if (diff_s[DW] == 1'b0) begin
            pr_next = diff_s[DW-1:0];
            q_bit   = 1'b1;
        end else begin
            pr_next = shifted_s[DW-1:0];
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/seq_restoring_div.sv
// Sequential restoring divider, 2*DW / DW -> DW quotient and remainder, one quotient bit per clock.
// Define DIV_TRUNC_EN for approximate mode, which skips the TRUNC_BITS quotient LSBs.
module seq_restoring_div
    import div_pkg::*;
#(
    parameter int DW         = DIV_DW_DEFAULT,
    parameter int TRUNC_BITS = DIV_TRUNC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            dbz,
    output logic            ovf
);

    localparam int CW = $clog2(DW + 1);
`ifdef DIV_TRUNC_EN
    localparam int N_INT = DW - TRUNC_BITS;
`else
    localparam int N_INT = DW;
`endif
    localparam logic [CW-1:0] N_STEPS = N_INT[CW-1:0];
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    if (DW < 2 || TRUNC_BITS < 1 || TRUNC_BITS > DW - 1) begin : g_bad_param
        $error("seq_restoring_div: need DW >= 2 and 1 <= TRUNC_BITS <= DW-1");
    end

    div_state_e      state_r;
    div_state_e      state_n_s;
    logic [DW-1:0]   pr_r;
    logic [DW-1:0]   lo_r;
    logic [DW-1:0]   dvs_r;
    logic [DW-2:0]   q_r;
    logic [CW-1:0]   cnt_r;

    logic            accept_s;
    logic            err_dbz_s;
    logic            err_ovf_s;
    logic            last_s;
    logic [DW-1:0]   step_pr_s;
    logic            step_q_s;
    logic [DW-1:0]   q_next_s;
    logic [DW-1:0]   q_result_s;

    div_step #(.DW(DW)) u_step (
        .pr           (pr_r),
        .dividend_bit (lo_r[DW-1]),
        .divisor      (dvs_r),
        .pr_next      (step_pr_s),
        .q_bit        (step_q_s)
    );

    // Quotient after the current step; in approximate mode the skipped LSBs read as zero.
    always_comb begin
        q_next_s = {q_r, step_q_s};
`ifdef DIV_TRUNC_EN
        q_result_s = q_next_s << TRUNC_BITS;
`else
        q_result_s = q_next_s;
`endif
    end

    // Next-state and control decode.
    always_comb begin
        state_n_s = state_r;
        accept_s  = 1'b0;
        err_dbz_s = 1'b0;
        err_ovf_s = 1'b0;
        last_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    if (divisor == {DW{1'b0}}) begin
                        err_dbz_s = 1'b1;
                        state_n_s = S_IDLE;
                    end else if (dividend[2*DW-1:DW] >= divisor) begin
                        err_ovf_s = 1'b1;
                        state_n_s = S_IDLE;
                    end else begin
                        state_n_s = S_RUN;
                    end
                end else begin
                    state_n_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_r == CNT_ONE) begin
                    last_s    = 1'b1;
                    state_n_s = S_IDLE;
                end else begin
                    state_n_s = S_RUN;
                end
            end
            default: begin
                state_n_s = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Operand capture, iteration datapath and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pr_r      <= {DW{1'b0}};
            lo_r      <= {DW{1'b0}};
            dvs_r     <= {DW{1'b0}};
            q_r       <= {(DW-1){1'b0}};
            cnt_r     <= {CW{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= {DW{1'b0}};
            remainder <= {DW{1'b0}};
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_s) begin
                if (err_dbz_s) begin
                    done      <= 1'b1;
                    dbz       <= 1'b1;
                    ovf       <= 1'b0;
                    quotient  <= {DW{1'b1}};
                    remainder <= dividend[DW-1:0];
                end else if (err_ovf_s) begin
                    done      <= 1'b1;
                    dbz       <= 1'b0;
                    ovf       <= 1'b1;
                    quotient  <= {DW{1'b1}};
                    remainder <= {DW{1'b0}};
                end else begin
                    busy  <= 1'b1;
                    pr_r  <= dividend[2*DW-1:DW];
                    lo_r  <= dividend[DW-1:0];
                    dvs_r <= divisor;
                    q_r   <= {(DW-1){1'b0}};
                    cnt_r <= N_STEPS;
                end
            end else if (state_r == S_RUN) begin
                pr_r  <= step_pr_s;
                lo_r  <= {lo_r[DW-2:0], 1'b0};
                q_r   <= q_next_s[DW-2:0];
                cnt_r <= cnt_r - CNT_ONE;
                if (last_s) begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    dbz       <= 1'b0;
                    ovf       <= 1'b0;
                    quotient  <= q_result_s;
                    remainder <= step_pr_s;
                end else begin
                    busy <= 1'b1;
                end
            end else begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_div.sv
// Scoreboard bench for seq_restoring_div: directed vectors with hand-computed results for both build modes.
module tb_seq_restoring_div;

    localparam int DW = 8;
`ifdef DIV_TRUNC_EN
    localparam int N = 6;
`else
    localparam int N = 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        dbz;
    logic        ovf;

    always #5 clk = ~clk;

    seq_restoring_div #(.DW(DW), .TRUNC_BITS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
        int         cyc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result, at the expected cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no result pending", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, ".quotient"},  32'(quotient),  32'(e.q));
                chk({e.name, ".remainder"}, 32'(remainder), 32'(e.r));
                chk({e.name, ".dbz"},       32'(dbz),       32'(e.dbz));
                chk({e.name, ".ovf"},       32'(ovf),       32'(e.ovf));
                chk({e.name, ".cycle"},     32'(cyc),       32'(e.cyc));
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input string nm, input logic [15:0] dvd, input logic [7:0] dvs,
                         input logic [7:0] qx, input logic [7:0] rx,
                         input logic [7:0] qt, input logic [7:0] rt,
                         input logic dbz_e, input logic ovf_e);
        exp_t e;
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk);
        #1;
`ifdef DIV_TRUNC_EN
        e.q = qt;
        e.r = rt;
`else
        e.q = qx;
        e.r = rx;
`endif
        e.dbz  = dbz_e;
        e.ovf  = ovf_e;
        e.cyc  = (dbz_e || ovf_e) ? cyc : cyc + N;
        e.name = nm;
        sb.push_back(e);
        if (!(dbz_e || ovf_e)) chk({nm, ".busy"}, 32'(busy), 32'd1);
        start    = 1'b0;
        dividend = 16'hFFFF;
        divisor  = 8'h00;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.timeout: got %0d results pending, expected 0 within 60 cycles", nm, sb.size());
        end
    endtask

    task automatic wait_done(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.timeout: got no done, expected one within 40 cycles", nm);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'h0000;
        divisor  = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset.busy",      32'(busy),      32'd0);
        chk("reset.done",      32'(done),      32'd0);
        chk("reset.quotient",  32'(quotient),  32'd0);
        chk("reset.remainder", 32'(remainder), 32'd0);
        chk("reset.flags",     32'({dbz, ovf}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue("div1",    16'h2A6B, 8'h5B, 8'd119, 8'd30,  8'd116, 8'd75,  1'b0, 1'b0);
        wait_idle("div1");
        issue("max",     16'hFEFF, 8'hFF, 8'd255, 8'd254, 8'd252, 8'd254, 1'b0, 1'b0);
        wait_idle("max");
        issue("ovf",     16'h6400, 8'h32, 8'hFF,  8'h00,  8'hFF,  8'h00,  1'b0, 1'b1);
        wait_idle("ovf");
        issue("ovf_eq",  16'h0505, 8'h05, 8'hFF,  8'h00,  8'hFF,  8'h00,  1'b0, 1'b1);
        wait_idle("ovf_eq");
        issue("dbz",     16'h1234, 8'h00, 8'hFF,  8'h34,  8'hFF,  8'h34,  1'b1, 1'b0);
        wait_idle("dbz");
        issue("zero",    16'h0000, 8'h01, 8'd0,   8'd0,   8'd0,   8'd0,   1'b0, 1'b0);
        wait_idle("zero");
        issue("by_one",  16'h00FF, 8'h01, 8'd255, 8'd0,   8'd252, 8'd0,   1'b0, 1'b0);
        wait_idle("by_one");

        // start held high with other operands while busy must be ignored
        issue("held",    16'h1000, 8'h20, 8'd128, 8'd0,   8'd128, 8'd0,   1'b0, 1'b0);
        dividend = 16'h0005;
        divisor  = 8'h03;
        start    = 1'b1;
        repeat (N - 3) @(negedge clk);
        start = 1'b0;
        wait_idle("held");

        // next start issued in the done cycle
        issue("b2bA",    16'h00FF, 8'h10, 8'd15,  8'd15,  8'd12,  8'd15,  1'b0, 1'b0);
        wait_done("b2bA");
        issue("b2bB",    16'h0100, 8'h07, 8'd36,  8'd4,   8'd36,  8'd1,   1'b0, 1'b0);
        wait_done("b2bB");
        issue("b2bC",    16'h1234, 8'h00, 8'hFF,  8'h34,  8'hFF,  8'h34,  1'b1, 1'b0);
        wait_idle("b2bC");

        // reset three cycles into a run discards it without a done
        dividend = 16'h2A6B;
        divisor  = 8'h5B;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.busy",      32'(busy),       32'd0);
        chk("midrst.done",      32'(done),       32'd0);
        chk("midrst.quotient",  32'(quotient),   32'd0);
        chk("midrst.remainder", 32'(remainder),  32'd0);
        chk("midrst.flags",     32'({dbz, ovf}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (N + 2) @(negedge clk);
        chk("midrst.no_done", 32'(quotient), 32'd0);

        issue("post_rst", 16'h0064, 8'h0A, 8'd10, 8'd0,   8'd8,   8'd5,   1'b0, 1'b0);
        wait_idle("post_rst");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
